mem_req_arbiter: RTL

MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

---
 rtl/mem_req_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter feeding one memory request at a time to a splitter.
// Holds the granted request until the splitter accepts it and reports done.
module mem_req_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_WIDTH     = 64,
    parameter int REQ_SIZE_WIDTH = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_REQ-1:0]                req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]     req_addr,
    input  logic [NUM_REQ*REQ_SIZE_WIDTH-1:0] req_size,
    output logic [NUM_REQ-1:0]                req_ready,
    output logic [ADDR_WIDTH-1:0]             out_addr,
    output logic [REQ_SIZE_WIDTH-1:0]         out_size,
    output logic                              out_valid,
    input  logic                              out_ready,
    input  logic                              out_done,
    output logic [2:0]                        grant_id,
    output logic                              busy
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_state_d;
    logic [PW-1:0]             r_ptr;
    logic [2:0]                r_gid;
    logic [ADDR_WIDTH-1:0]     r_addr;
    logic [REQ_SIZE_WIDTH-1:0] r_size;

    logic                      w_found;
    logic [PW-1:0]             w_win;
    logic [PW-1:0]             w_next_ptr;
    logic [ADDR_WIDTH-1:0]     w_win_addr;
    logic [REQ_SIZE_WIDTH-1:0] w_win_size;
    logic                      w_accept;

    // Round-robin pick: first valid at or above rr_ptr, else first valid from 0.
    always_comb begin
        w_found    = 1'b0;
        w_win      = '0;
        w_win_addr = '0;
        w_win_size = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && req_valid[i] && (PW'(i) >= r_ptr)) begin
                w_found    = 1'b1;
                w_win      = PW'(i);
                w_win_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_win_size = req_size[i*REQ_SIZE_WIDTH +: REQ_SIZE_WIDTH];
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && req_valid[i]) begin
                w_found    = 1'b1;
                w_win      = PW'(i);
                w_win_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_win_size = req_size[i*REQ_SIZE_WIDTH +: REQ_SIZE_WIDTH];
            end
        end
    end

    assign w_next_ptr = (w_win == PW'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;

    // Next-state logic; zero-size winners are accepted but never issued.
    always_comb begin
        w_state_d = r_state;
        w_accept  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_accept = 1'b1;
                    if (w_win_size != '0) begin
                        w_state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (out_ready) begin
                    w_state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (out_done) begin
                    w_state_d = IDLE;
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    // One-hot acceptance pulse, suppressed while reset is held.
    always_comb begin
        req_ready = '0;
        if (w_accept && !reset) begin
            req_ready[w_win] = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Grant bookkeeping and holding registers, updated only on acceptance.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr  <= '0;
            r_gid  <= '0;
            r_addr <= '0;
            r_size <= '0;
        end else if (w_accept) begin
            r_ptr  <= w_next_ptr;
            r_gid  <= 3'(w_win);
            r_addr <= w_win_addr;
            r_size <= w_win_size;
        end
    end

    assign out_valid = (r_state == ISSUE);
    assign busy      = (r_state != IDLE);
    assign out_addr  = r_addr;
    assign out_size  = r_size;
    assign grant_id  = r_gid;

endmodule
